lfsr_prbs_checker: RTL and testbench
====================================

# lfsr_prbs_checker

Receive-side checker for the LFSR pseudo-random bit stream produced by the Sierpinski/LFSR generator tile. It self-synchronises to an incoming serial PRBS16 stream and tracks lock with a HUNT/LOCKED state machine. Bit errors are reported as a registered pulse and a saturating error count. It sits at the receive end of the loopback or chip-to-chip link that carries the generator output.

## Interface
- `LOCK_COUNT`, default 32: consecutive predicted-bit matches, after fill, required to declare lock.
- `LOSS_THRESH`, default 8: errors without an intervening 16-bit clean run that force loss of lock.
- `ERR_W`, default 16: width of the error counter.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `bit_in` input 1: received PRBS bit, sampled when `bit_valid`=1.
- `bit_valid` input 1: qualifies `bit_in`; one bit per cycle maximum.
- `clr_cnt` input 1: synchronous clear of `err_count`.
- `locked` output 1: 1 while the FSM is in LOCKED.
- `err_pulse` output 1: one-cycle pulse per mismatched bit while LOCKED.
- `err_count` output ERR_W: saturating count of errors while LOCKED.

## Operation
- Polynomial: x^16+x^14+x^13+x^11+1, Fibonacci form. Shift register `sr[15:0]`. Prediction `p = sr[15]^sr[13]^sr[12]^sr[10]`. Shift is `sr <= {sr[14:0], x}`.
- Every rule below applies only on cycles with `bit_valid`=1; otherwise all state holds and `err_pulse`=0.
- HUNT: `x = bit_in`, so the checker self-synchronises. `fill_cnt` counts 0..16.
  - While `fill_cnt` < 16, matches are not evaluated.
  - After fill, a match is `bit_in == p` with `sr != 0` (zero-stream rejection). `match_cnt` increments on a match and clears on a mismatch or while `sr == 0`.
  - When `match_cnt` reaches LOCK_COUNT, the FSM goes to LOCKED.
- LOCKED: `x = p`, so the register free-runs and errors do not corrupt the reference.
  - Mismatch: `err_pulse`, `err_count`+1 (saturates at all-ones), `bad_cnt`+1, `good_run` cleared.
  - Match: `good_run`+1. At 16, `bad_cnt` and `good_run` clear.
  - When `bad_cnt` reaches LOSS_THRESH, the FSM goes to HUNT and clears `fill_cnt`, `match_cnt`, `bad_cnt` and `good_run`. `sr` is kept.
- `clr_cnt` has priority over a simultaneous increment: `err_count` becomes 0 that cycle.
- The mismatch that causes loss of lock still pulses `err_pulse` and counts.
- HUNT never produces `err_pulse` or touches `err_count`.

## Timing
- Reset values: `locked`=0, `err_pulse`=0, `err_count`=0, `sr`=0, FSM=HUNT, all internal counters 0.
- Reset is asynchronous. Asserting it mid-stream clears all state immediately. After release, hunting restarts on the next `bit_valid`.
- All outputs are registered. `err_pulse` and the `err_count` update are visible the cycle after the offending `bit_valid` cycle.
- `locked` rises the cycle after the valid bit that completes LOCK_COUNT. With defaults and a clean stream, that is the 48th valid bit after reset.
- `locked` falls the cycle after the LOSS_THRESH-th qualifying error.
- Gaps in `bit_valid` of any length are transparent: the stream is indexed by valid bits, not cycles.
- Throughput is one bit per clock.

## Configuration
- `LFSR_CHK_ERRCNT_EN` defined: `err_count` is implemented as described.
- Undefined: no counter flops; `err_count` is tied to 0 and `clr_cnt` is ignored. `err_pulse`, `locked` and the FSM are unchanged.

## Test plan
- Clean stream: generator seeded 0xACE1, `bit_valid` held at 1. Required: `locked`=1 the cycle after bit 48, then `err_pulse` never asserts and `err_count`=0 over 70000 bits (a full period plus margin).
- Single error: after lock, invert bit 100. Required: exactly one `err_pulse`, one cycle after that bit; `err_count`=1; `locked` stays 1.
- Loss of lock: after lock, invert 8 bits spaced 4 apart. Required: `err_count`=8, `locked` falls after the 8th; a clean stream then relocks 48 valid bits later.
- All-zero input: 1000 zero bits. Required: `locked` stays 0.
- `bit_valid` toggling 1/0 on a clean stream. Required: lock after 48 valid bits (about 96 cycles) and no errors.
- `clr_cnt` coincident with an error: `err_count`=0 the next cycle.
- Reset mid-LOCKED with `err_count`=5: `locked`=0 and `err_count`=0 before the next clock edge.
- Macro undefined, repeat the single-error case. Required: `err_pulse` still asserts once and `err_count`=0.

Source files
------------

// File: rtl/lfsr_prbs_checker.sv
// Self-synchronising PRBS16 (x^16+x^14+x^13+x^11+1) receive checker with HUNT/LOCKED tracking.
// Define LFSR_CHK_ERRCNT_EN to build the saturating err_count register; otherwise it reads 0.
module lfsr_prbs_checker #(
    parameter int LOCK_COUNT  = 32,
    parameter int LOSS_THRESH = 8,
    parameter int ERR_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam int MW = (LOCK_COUNT  > 1) ? $clog2(LOCK_COUNT + 1)  : 1;
    localparam int BW = (LOSS_THRESH > 1) ? $clog2(LOSS_THRESH + 1) : 1;

    typedef enum logic {S_HUNT, S_LOCKED} state_t;

    state_t          state, state_nxt;
    logic [15:0]     sr, sr_nxt;
    logic [4:0]      fill_cnt, fill_nxt;
    logic [MW-1:0]   match_cnt, match_nxt;
    logic [BW-1:0]   bad_cnt, bad_nxt;
    logic [4:0]      good_run, good_nxt;
    logic            pred;
    logic            err_inc;

    assign pred = sr[15] ^ sr[13] ^ sr[12] ^ sr[10];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_HUNT;
            sr        <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            bad_cnt   <= '0;
            good_run  <= '0;
            err_pulse <= 1'b0;
        end else begin
            state     <= state_nxt;
            sr        <= sr_nxt;
            fill_cnt  <= fill_nxt;
            match_cnt <= match_nxt;
            bad_cnt   <= bad_nxt;
            good_run  <= good_nxt;
            err_pulse <= err_inc;
        end
    end

    // In HUNT the register loads received bits; once LOCKED it free-runs on its own prediction
    // so that line errors cannot corrupt the reference.
    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        fill_nxt  = fill_cnt;
        match_nxt = match_cnt;
        bad_nxt   = bad_cnt;
        good_nxt  = good_run;
        err_inc   = 1'b0;
        if (bit_valid) begin
            case (state)
                S_HUNT: begin
                    sr_nxt = {sr[14:0], bit_in};
                    if (fill_cnt != 5'd16) begin
                        fill_nxt = fill_cnt + 5'd1;
                    end else if ((bit_in == pred) && (sr != 16'h0000)) begin
                        if (match_cnt == MW'(LOCK_COUNT - 1)) begin
                            state_nxt = S_LOCKED;
                            match_nxt = '0;
                        end else begin
                            match_nxt = match_cnt + MW'(1);
                        end
                    end else begin
                        match_nxt = '0;
                    end
                end
                S_LOCKED: begin
                    sr_nxt = {sr[14:0], pred};
                    if (bit_in != pred) begin
                        err_inc  = 1'b1;
                        good_nxt = '0;
                        if (bad_cnt == BW'(LOSS_THRESH - 1)) begin
                            state_nxt = S_HUNT;
                            fill_nxt  = '0;
                            match_nxt = '0;
                            bad_nxt   = '0;
                        end else begin
                            bad_nxt = bad_cnt + BW'(1);
                        end
                    end else if (good_run == 5'd15) begin
                        good_nxt = '0;
                        bad_nxt  = '0;
                    end else begin
                        good_nxt = good_run + 5'd1;
                    end
                end
                default: begin
                    state_nxt = S_HUNT;
                end
            endcase
        end
    end

    assign locked = (state == S_LOCKED);

`ifdef LFSR_CHK_ERRCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (clr_cnt) begin
            err_count <= '0;
        end else if (err_inc && (err_count != {ERR_W{1'b1}})) begin
            err_count <= err_count + ERR_W'(1);
        end
    end
`else
    logic unused_clr_cnt;
    assign unused_clr_cnt = clr_cnt;
    assign err_count      = '0;
`endif

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Scoreboard bench for lfsr_prbs_checker: stimulus pushes one expectation per clock,
// a monitor pops and compares just after each rising edge.
module tb_lfsr_prbs_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        clr_cnt = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;

    typedef struct {
        logic locked;
        logic pulse;
        int   count;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] gen_sr = 16'hACE1;

    lfsr_prbs_checker #(
        .LOCK_COUNT (32),
        .LOSS_THRESH(8),
        .ERR_W      (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bit_in   (bit_in),
        .bit_valid(bit_valid),
        .clr_cnt  (clr_cnt),
        .locked   (locked),
        .err_pulse(err_pulse),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic int exp_cnt(input int n);
`ifdef LFSR_CHK_ERRCNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference generator: same Fibonacci recurrence, emitting the newly computed bit.
    task automatic next_prbs(output logic b);
        b      = gen_sr[15] ^ gen_sr[13] ^ gen_sr[12] ^ gen_sr[10];
        gen_sr = {gen_sr[14:0], b};
    endtask

    task automatic applyStimulus(input logic v, input logic b, input logic c,
                                 input logic el, input logic ep, input int ec);
        exp_t e;
        @(negedge clk);
        bit_valid = v;
        bit_in    = b;
        clr_cnt   = c;
        e.locked  = el;
        e.pulse   = ep;
        e.count   = ec;
        sb.push_back(e);
    endtask

    task automatic drain();
        @(posedge clk);
        #2;
        bit_valid = 1'b0;
        clr_cnt   = 1'b0;
    endtask

    task automatic resetDut();
        bit_valid = 1'b0;
        clr_cnt   = 1'b0;
        rst       = 1'b1;
        #1;
        checkOutput("reset_locked", int'(locked), 0);
        checkOutput("reset_pulse", int'(err_pulse), 0);
        checkOutput("reset_count", int'(err_count), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                checkOutput("locked", int'(locked), int'(mon_e.locked));
                checkOutput("err_pulse", int'(err_pulse), int'(mon_e.pulse));
                checkOutput("err_count", int'(err_count), mon_e.count);
            end
        end
    end

    initial begin
        logic b;
        int   vcount;
        #2;
        resetDut();

        // Clean stream: lock after 48 bits, then no errors across a full period.
        for (int i = 1; i <= 70000; i++) begin
            next_prbs(b);
            applyStimulus(1'b1, b, 1'b0, (i >= 48), 1'b0, 0);
        end

        // Single inverted bit while locked.
        for (int i = 1; i <= 150; i++) begin
            next_prbs(b);
            applyStimulus(1'b1, (i == 100) ? ~b : b, 1'b0, 1'b1, (i == 100),
                          exp_cnt((i >= 100) ? 1 : 0));
        end

        // Clear coinciding with an error wins over the increment.
        next_prbs(b);
        applyStimulus(1'b1, ~b, 1'b1, 1'b1, 1'b1, 0);
        for (int i = 1; i <= 20; i++) begin
            next_prbs(b);
            applyStimulus(1'b1, b, 1'b0, 1'b1, 1'b0, 0);
        end

        // Five isolated errors, then an asynchronous reset while locked.
        for (int k = 1; k <= 5; k++) begin
            next_prbs(b);
            applyStimulus(1'b1, ~b, 1'b0, 1'b1, 1'b1, exp_cnt(k));
            for (int i = 1; i <= 20; i++) begin
                next_prbs(b);
                applyStimulus(1'b1, b, 1'b0, 1'b1, 1'b0, exp_cnt(k));
            end
        end
        drain();
        resetDut();

        // Loss of lock: eight errors four bits apart, then relock 48 bits later.
        for (int i = 1; i <= 58; i++) begin
            next_prbs(b);
            applyStimulus(1'b1, b, 1'b0, (i >= 48), 1'b0, 0);
        end
        for (int k = 1; k <= 8; k++) begin
            next_prbs(b);
            applyStimulus(1'b1, ~b, 1'b0, (k < 8), 1'b1, exp_cnt(k));
            if (k < 8) begin
                for (int i = 1; i <= 3; i++) begin
                    next_prbs(b);
                    applyStimulus(1'b1, b, 1'b0, 1'b1, 1'b0, exp_cnt(k));
                end
            end
        end
        for (int j = 1; j <= 52; j++) begin
            next_prbs(b);
            applyStimulus(1'b1, b, 1'b0, (j >= 48), 1'b0, exp_cnt(8));
        end
        drain();
        resetDut();

        // All-zero input must never lock.
        for (int i = 1; i <= 1000; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        end
        drain();
        resetDut();

        // bit_valid toggling; junk on idle cycles must be ignored.
        vcount = 0;
        for (int c = 0; c < 104; c++) begin
            if ((c % 2) == 0) begin
                next_prbs(b);
                vcount++;
                applyStimulus(1'b1, b, 1'b0, (vcount >= 48), 1'b0, 0);
            end else begin
                applyStimulus(1'b0, ~b, 1'b0, (vcount >= 48), 1'b0, 0);
            end
        end
        drain();
        repeat (2) @(posedge clk);
        checkOutput("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
